// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES request scheduler slice.
//   sched_state_e : scheduler FSM states (IDLE, ROUND, DONE)
//   AES_ROUNDS    : number of AES-128 rounds sequenced through the round unit
//   AES_BLK_W     : block / key width in bits
//   RND_W         : width of the round-number bus
package aes_sched_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned RND_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } sched_state_e;

endpackage

// File: rtl/aes_req_scheduler_if.sv
// Client-side request/response bundle of the AES request scheduler.
//   req_valid  : per-requester request valid
//   req_ready  : one-hot accept strobe
//   req_pt     : packed plaintexts, requester i at [128i+127:128i]
//   req_key    : packed keys, same packing
//   resp_valid : ciphertext available
//   resp_ready : consumer accepts the response
//   resp_id    : owner of resp_ct
//   resp_ct    : ciphertext
// Modports: master = client side, slave = scheduler side.
interface aes_req_scheduler_if
  import aes_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*AES_BLK_W-1:0] req_pt;
  logic [N_REQ*AES_BLK_W-1:0] req_key;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [AES_BLK_W-1:0]       resp_ct;

  modport master (
    output req_valid, req_pt, req_key, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_ct
  );

  modport slave (
    input  req_valid, req_pt, req_key, resp_ready,
    output req_ready, resp_valid, resp_id, resp_ct
  );

endinterface

// File: rtl/aes_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index (pointer register lives in the parent)
//   en        : grant enable; no grant when low
//   grant     : one-hot grant
//   grant_idx : binary index of the granted requester
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  int unsigned idx;
  logic        found;

  // Scan upward from ptr, wrapping mod N_REQ; first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one iterative AES-128 round datapath among N_REQ requesters.
// Grants round-robin, applies the initial AddRoundKey, drives rounds 1..10
// through the external round unit (one per cycle) and returns the tagged
// ciphertext on a valid/ready response channel.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   cli           : request/response bundle (slave modport)
//   busy          : high whenever the FSM is not IDLE
//   rnd_state_in  : state word to the round datapath
//   rnd_key_in    : previous round key to the datapath
//   rnd_num       : round number 1..10, 0 outside ROUND
//   rnd_state_out : datapath round result
//   rnd_key_out   : round key for rnd_num
// Optional build macro AES_SCHED_PERF_EN adds:
//   blk_count     : saturating count of response handshakes
//   stall_cycles  : saturating count of DONE cycles with resp_ready low
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_req_scheduler_if.slave   cli,
  output logic                 busy,
  output logic [AES_BLK_W-1:0] rnd_state_in,
  output logic [AES_BLK_W-1:0] rnd_key_in,
  output logic [RND_W-1:0]     rnd_num,
  input  logic [AES_BLK_W-1:0] rnd_state_out,
  input  logic [AES_BLK_W-1:0] rnd_key_out
`ifdef AES_SCHED_PERF_EN
  ,
  output logic [31:0]          blk_count,
  output logic [31:0]          stall_cycles
`endif
);

  sched_state_e         state_q;
  logic [AES_BLK_W-1:0] st_q;
  logic [AES_BLK_W-1:0] key_q;
  logic [ID_W-1:0]      id_q;
  logic [RND_W-1:0]     round_q;
  logic [ID_W-1:0]      ptr_q;
  logic                 resp_valid_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [AES_BLK_W-1:0] resp_ct_q;

  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      g_idx;
  logic [AES_BLK_W-1:0] g_pt;
  logic [AES_BLK_W-1:0] g_key;

  // Grant only from IDLE and never while reset is asserted, so req_ready
  // reads 0 during reset even with requests pending.
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (cli.req_valid),
    .ptr       (ptr_q),
    .en        (state_q == IDLE && !reset),
    .grant     (grant),
    .grant_idx (g_idx)
  );

  assign g_pt  = cli.req_pt[32'(g_idx)*AES_BLK_W +: AES_BLK_W];
  assign g_key = cli.req_key[32'(g_idx)*AES_BLK_W +: AES_BLK_W];

  assign cli.req_ready  = grant;
  assign cli.resp_valid = resp_valid_q;
  assign cli.resp_id    = resp_id_q;
  assign cli.resp_ct    = resp_ct_q;
  assign busy           = (state_q != IDLE);
  assign rnd_state_in   = st_q;
  assign rnd_key_in     = key_q;
  assign rnd_num        = (state_q == ROUND) ? round_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      st_q         <= '0;
      key_q        <= '0;
      id_q         <= '0;
      round_q      <= '0;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_ct_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            st_q    <= g_pt ^ g_key;
            key_q   <= g_key;
            id_q    <= g_idx;
            round_q <= RND_W'(1);
            ptr_q   <= (32'(g_idx) == N_REQ - 1) ? '0 : g_idx + ID_W'(1);
            state_q <= ROUND;
          end
        end
        ROUND: begin
          st_q  <= rnd_state_out;
          key_q <= rnd_key_out;
          if (round_q == RND_W'(AES_ROUNDS)) begin
            resp_ct_q    <= rnd_state_out;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            round_q <= round_q + RND_W'(1);
          end
        end
        DONE: begin
          if (cli.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_count    <= '0;
      stall_cycles <= '0;
    end else if (state_q == DONE) begin
      if (cli.resp_ready && blk_count != '1)
        blk_count <= blk_count + 32'd1;
      if (!cli.resp_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Self-checking bench for aes_req_scheduler. Provides a behavioural AES
// round unit, a transaction-level model of the scheduler checked every cycle,
// and literal ciphertext/ordering expectations from known AES vectors.
// Honours AES_SCHED_PERF_EN for the optional counters.
module tb_aes_req_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         busy;
  logic [127:0] rnd_state_in, rnd_key_in, rnd_state_out, rnd_key_out;
  logic [3:0]   rnd_num;
`ifdef AES_SCHED_PERF_EN
  logic [31:0]  blk_count, stall_cycles;
`endif

  aes_req_scheduler_if #(.N_REQ(N), .ID_W(IW)) cli ();

  aes_req_scheduler #(.N_REQ(N), .ID_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cli           (cli),
    .busy          (busy),
    .rnd_state_in  (rnd_state_in),
    .rnd_key_in    (rnd_key_in),
    .rnd_num       (rnd_num),
    .rnd_state_out (rnd_state_out),
    .rnd_key_out   (rnd_key_out)
`ifdef AES_SCHED_PERF_EN
    ,
    .blk_count     (blk_count),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the field inverse x^254 followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01, b = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, b);
      b = gmul(b, b);
      e = e >> 1;
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_fn(input logic [127:0] k, input int rnd);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, t;
    for (int i = 1; i < rnd; i++) rc = xt(rc);
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                            input bit last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end else begin
      for (int i = 0; i < 16; i++) a[i] = b[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s = pt ^ key, k = key;
    for (int r = 1; r <= 10; r++) begin
      k = key_fn(k, r);
      s = round_fn(s, k, r == 10);
    end
    return s;
  endfunction

  // External round unit seen by the DUT.
  always_comb begin
    rnd_key_out   = key_fn(rnd_key_in, int'(rnd_num));
    rnd_state_out = round_fn(rnd_state_in, rnd_key_out, rnd_num == 4'd10);
  end

  // ---------------- checking infrastructure ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  int           grant_log[$];
  int           grant_cyc[$];
  int           resp_id_log[$];
  logic [127:0] resp_ct_log[$];
  int           resp_cyc[$];

  // Transaction-level model: m_cnt is cycles since grant (0 = idle,
  // 1..10 = round k in flight, 11 = response pending).
  int           m_ptr = 0, m_cnt = 0, m_id = 0, m_rid = 0;
  logic [127:0] m_ct = '0, m_rct = '0;
  int           m_blk = 0, m_stall = 0;
  int           g;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    cyc++;
    g       = -1;
    exp_rdy = '0;
    if (m_cnt == 0 && !reset)
      for (int k = 0; k < N; k++)
        if (g < 0 && cli.req_valid[(m_ptr+k)%N]) g = (m_ptr + k) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;

    check("req_ready",  cli.req_ready,  exp_rdy);
    check("busy",       busy,           m_cnt != 0);
    check("rnd_num",    rnd_num,        (m_cnt >= 1 && m_cnt <= 10) ? m_cnt : 0);
    check("resp_valid", cli.resp_valid, m_cnt == 11);
    check("resp_id",    cli.resp_id,    m_rid);
    check("resp_ct",    cli.resp_ct,    m_rct);
`ifdef AES_SCHED_PERF_EN
    check("blk_count",    blk_count,    m_blk);
    check("stall_cycles", stall_cycles, m_stall);
`endif

    for (int k = 0; k < N; k++)
      if (cli.req_ready[k]) begin grant_log.push_back(k); grant_cyc.push_back(cyc); end
    if (cli.resp_valid && cli.resp_ready) begin
      resp_id_log.push_back(int'(cli.resp_id));
      resp_ct_log.push_back(cli.resp_ct);
      resp_cyc.push_back(cyc);
    end

    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_rid = 0; m_rct = '0; m_blk = 0; m_stall = 0;
    end else if (m_cnt == 0) begin
      if (g >= 0) begin
        m_cnt = 1;
        m_id  = g;
        m_ptr = (g + 1) % N;
        m_ct  = aes_enc(cli.req_pt[g*128 +: 128], cli.req_key[g*128 +: 128]);
      end
    end else if (m_cnt < 10) begin
      m_cnt++;
    end else if (m_cnt == 10) begin
      m_cnt = 11; m_rid = m_id; m_rct = m_ct;
    end else if (cli.resp_ready) begin
      m_cnt = 0; m_blk++;
    end else begin
      m_stall++;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [127:0] pt, input logic [127:0] key);
    cli.req_pt[idx*128 +: 128]  = pt;
    cli.req_key[idx*128 +: 128] = key;
  endtask

  task automatic request(input int idx, input logic [127:0] pt, input logic [127:0] key);
    bit got = 1'b0;
    set_req(idx, pt, key);
    cli.req_valid[idx] = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = cli.req_ready[idx];
      tick();
    end
    cli.req_valid[idx] = 1'b0;
    vec_cnt++;
    if (!got) begin err_cnt++; $display("FAIL grant_timeout req%0d: got none, expected grant", idx); end
  endtask

  task automatic wait_resps(input int n, input int budget);
    for (int i = 0; i < budget && resp_id_log.size() < n; i++) tick();
    vec_cnt++;
    if (resp_id_log.size() < n) begin
      err_cnt++;
      $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_id_log.size(), n);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  int base_g, base_r, n_r;
  bit seen;

  initial begin
    reset          = 1'b1;
    cli.req_valid  = '0;
    cli.req_pt     = '0;
    cli.req_key    = '0;
    cli.resp_ready = 1'b1;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_resp_valid", cli.resp_valid, 0);
    reset = 1'b0;

    // Single requester 0, FIPS-197 appendix B vector, latency 11.
    request(0, PT1, K1);
    wait_resps(1, 40);
    if (resp_id_log.size() >= 1) begin
      check("t1_id", resp_id_log[0], 0);
      check("t1_ct", resp_ct_log[0], CT1);
      check("t1_latency", resp_cyc[0] - grant_cyc[0], 11);
    end

    // Requester 2, FIPS-197 appendix C.1 vector.
    tick();
    request(2, PT2, K2);
    wait_resps(2, 40);
    if (resp_id_log.size() >= 2) begin
      check("t2_id", resp_id_log[1], 2);
      check("t2_ct", resp_ct_log[1], CT2);
    end

    // All four continuously valid from pointer 0.
    tick();
    do_reset(2);
    set_req(0, PT1, K1);
    set_req(1, '0, '0);
    set_req(2, PT2, K2);
    set_req(3, '1, '1);
    base_g = grant_log.size();
    base_r = resp_id_log.size();
    cli.req_valid = '1;
    for (int i = 0; i < 100 && grant_log.size() < base_g + 5; i++) tick();
    cli.req_valid = '0;
    wait_resps(base_r + 5, 80);
    if (grant_log.size() >= base_g + 5 && resp_id_log.size() >= base_r + 5) begin
      for (int i = 0; i < 5; i++) check("t3_grant_order", grant_log[base_g+i], i % 4);
      for (int i = 1; i < 5; i++)
        check("t3_grant_gap", grant_cyc[base_g+i] - grant_cyc[base_g+i-1], 12);
      for (int i = 0; i < 5; i++) check("t3_resp_id", resp_id_log[base_r+i], i % 4);
      check("t3_ct0", resp_ct_log[base_r],   CT1);
      check("t3_ct1", resp_ct_log[base_r+1], CT0);
      check("t3_ct2", resp_ct_log[base_r+2], CT2);
      check("t3_ct0b", resp_ct_log[base_r+4], CT1);
    end

    // Consumer stalls 5 cycles in DONE.
    tick();
    cli.resp_ready = 1'b0;
    request(3, PT2, K1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (cli.resp_valid) seen = 1'b1;
      else tick();
    end
    check("t4_resp_seen", seen, 1);
    repeat (5) tick();
    check("t4_busy", busy, 1);
    check("t4_hold_valid", cli.resp_valid, 1);
    check("t4_hold_id", cli.resp_id, 3);
    cli.resp_ready = 1'b1;
    repeat (2) tick();
`ifdef AES_SCHED_PERF_EN
    check("t4_stall_cycles", stall_cycles, 5);
    check("t4_blk_count", blk_count, 6);
`endif

    // Reset while round 5 is in flight.
    request(1, PT1, K2);
    repeat (4) tick();
    check("t5_rnd5", rnd_num, 5);
    n_r = resp_id_log.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_rnd_num", rnd_num, 0);
    check("t5_resp_ct", cli.resp_ct, 0);
    repeat (25) tick();
    check("t5_no_resp", resp_id_log.size(), n_r);
    request(0, PT1, K1);
    wait_resps(n_r + 1, 40);
    if (resp_id_log.size() >= n_r + 1) begin
      check("t5_after_id", resp_id_log[n_r], 0);
      check("t5_after_ct", resp_ct_log[n_r], CT1);
    end

    // One-cycle pulse on requester 1 while busy is never granted.
    tick();
    base_g = grant_log.size();
    n_r    = resp_id_log.size();
    request(2, PT2, K2);
    repeat (3) tick();
    cli.req_valid[1] = 1'b1;
    tick();
    cli.req_valid[1] = 1'b0;
    repeat (30) tick();
    check("t6_resp_cnt", resp_id_log.size(), n_r + 1);
    check("t6_grant_cnt", grant_log.size(), base_g + 1);
    for (int i = n_r; i < resp_id_log.size(); i++) check("t6_resp_id", resp_id_log[i], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares one iterative AES-128 round datapath among N_REQ requesters.
- Grants requesters round-robin, performs the initial AddRoundKey, and sequences rounds 1..10 through the external round unit, one round per cycle.
- Returns the ciphertext tagged with the requester ID over a valid/ready response channel.
- Sits between the client ports (password/vault engines) and the single shared round datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot accept strobe, at most one bit set.
- req_pt  in  N_REQ*128  plaintexts; requester i occupies bits [128i+127:128i].
- req_key  in  N_REQ*128  cipher keys, same packing as req_pt.
- resp_valid  out  1  ciphertext available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester that owns resp_ct.
- resp_ct  out  128  ciphertext.
- busy  out  1  high in every state except IDLE.
- rnd_state_in  out  128  state word to the round datapath.
- rnd_key_in  out  128  previous round key to the datapath.
- rnd_num  out  4  round number 1..10; 0 when idle.
- rnd_state_out  in  128  datapath result: SubBytes, ShiftRows, MixColumns (omitted when rnd_num==10), then AddRoundKey.
- rnd_key_out  in  128  round key for rnd_num, derived by the datapath from rnd_key_in.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_ct=0, busy=0, rnd_num=0, internal state/key registers=0, RR pointer=0, FSM=IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE, some req_valid bit set:
  - Pick the first set bit scanning upward from the RR pointer, wrapping mod N_REQ.
  - Pulse req_ready[g] for exactly this cycle; req_ready is combinational from IDLE and the grant.
  - Register state <= req_pt[g]^req_key[g], key <= req_key[g], id <= g, round <= 1.
  - RR pointer <= (g+1) mod N_REQ. Go to ROUND.
- IDLE, no req_valid: stay; all outputs hold.
- ROUND:
  - Drive rnd_state_in=state, rnd_key_in=key, rnd_num=round.
  - Each cycle: state <= rnd_state_out, key <= rnd_key_out.
  - round<10: round <= round+1.
  - round==10: resp_ct <= rnd_state_out, resp_id <= id, resp_valid <= 1. Go to DONE.
- DONE:
  - resp_valid, resp_id and resp_ct are held stable until resp_valid && resp_ready.
  - On handshake, next cycle: resp_valid=0, FSM=IDLE.
  - No new grant is issued in the handshake cycle.
- Latency: accept at cycle T, resp_valid high at T+11. Throughput: one block per 12 cycles with resp_ready tied high.
- req_valid may drop in any cycle without req_ready; such a request is simply not granted. Plaintext and key are sampled only in the grant cycle.
- Fairness: a requester held continuously valid is granted within N_REQ grants.
- Reset mid-ROUND or mid-DONE: the block is discarded and no response is emitted. The RR pointer returns to 0.
- rnd_num is 0 outside ROUND, so the datapath sees a default rcon.

Optional Feature:
- Macro: AES_SCHED_PERF_EN.
- Defined:
  - Adds output blk_count (32 bits), reset to 0.
  - Increments on each resp handshake and saturates at 32'hFFFF_FFFF.
  - Adds output stall_cycles (32 bits, saturating), which counts DONE cycles with resp_ready=0.
- Undefined: neither port exists; there are no extra registers.

Decomposition:
- Package aes_sched_pkg:
  - FSM state enum {IDLE, ROUND, DONE}.
  - AES_ROUNDS=10, AES_BLK_W=128, RND_W=4.
- Sub-module rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: request vector, pointer, enable. Outputs: one-hot grant, binary grant index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single requester 0: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, resp_ready=1 -> resp_valid at T+11, resp_ct=3925841d02dc09fbdc118597196a0b32, resp_id=0.
- Requester 2: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> resp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=2.
- All four requesters valid continuously from pointer 0 -> grant order 0,1,2,3,0. Each ciphertext matches its own vector. Grants are 12 cycles apart.
- resp_ready held low 5 cycles in DONE -> resp_valid, resp_ct and resp_id stay stable; no req_ready pulses; busy=1. PERF build: stall_cycles=5.
- reset asserted at round 5 -> next cycle all outputs at reset values; no resp_valid ever appears for the aborted block; the next request completes correctly.
- req_valid[1] pulsed for one cycle while busy -> never granted, no response with resp_id=1.
